// File: rtl/hs_deserializer.sv
// ---------------------------------------------------------------------------
// hs_deserializer
//
// Receive-side HS deserializer for a D-PHY data lane. It takes two serial
// bits per RX_DDR_clk rising edge and hunts for the HS sync byte at either
// bit offset. Once locked, it assembles LSB-first bytes and delivers one
// byte every 4 cycles with a one-cycle valid strobe.
//
// Optional feature (macro RX_SYNC_ERR_EN):
//   defined   - HUNT also accepts a window one bit away from SYNC_WORD.
//               Such a lock pulses ErrSotHS together with SyncHS.
//   undefined - exact sync match only; ErrSotHS is tied low.
//
// Parameters:
//   SYNC_WORD      HS sync byte, sent LSB first (default 8'hB8)
//   HUNT_TIMEOUT   HUNT cycles without a match before ErrSyncTimeout pulses;
//                  0 disables the timeout
//
// Ports:
//   RX_DDR_clk      in   sampling clock, two bits per rising edge
//   RX_rst_n        in   asynchronous active-low reset
//   Enable          in   HS receive enable; low forces IDLE
//   Serial_B1       in   earlier bit of the pair (bit 2k)
//   Serial_B2       in   later bit of the pair (bit 2k+1)
//   RX_BYTE_DATA    out  assembled byte, LSB = first received bit
//   RX_BYTE_valid   out  one-cycle strobe, RX_BYTE_DATA valid this cycle
//   SyncHS          out  one-cycle pulse when lock is achieved
//   RX_locked       out  high while locked
//   ErrSotHS        out  one-cycle pulse when sync was accepted with a 1-bit error
//   ErrSyncTimeout  out  one-cycle pulse on hunt timeout
// ---------------------------------------------------------------------------
module hs_deserializer #(
  parameter logic [7:0] SYNC_WORD    = 8'hB8,
  parameter int         HUNT_TIMEOUT = 64
) (
  input  logic       RX_DDR_clk,
  input  logic       RX_rst_n,
  input  logic       Enable,
  input  logic       Serial_B1,
  input  logic       Serial_B2,
  output logic [7:0] RX_BYTE_DATA,
  output logic       RX_BYTE_valid,
  output logic       SyncHS,
  output logic       RX_locked,
  output logic       ErrSotHS,
  output logic       ErrSyncTimeout
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HUNT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  // Hunt counter is sized to hold HUNT_TIMEOUT-1, the value on which the
  // timeout fires.
  localparam int HCW = (HUNT_TIMEOUT > 1) ? $clog2(HUNT_TIMEOUT) : 1;
  localparam logic [HCW-1:0] HUNT_LAST =
    HCW'((HUNT_TIMEOUT > 0) ? HUNT_TIMEOUT - 1 : 0);

  logic [1:0]     state;
  logic           align;
  logic [1:0]     pair_cnt;
  logic [HCW-1:0] hunt_cnt;
  logic           byte_pend;

  // Bit history, newest bit in [9]. Bit 0 of the conceptual 10-bit history
  // never falls inside either window, so it is not stored.
  logic [9:1]     hist;
  logic [9:1]     hist_shift;

  logic [7:0]     win_even;
  logic [7:0]     win_odd;
  logic [7:0]     win_sel;
  logic           exact_even;
  logic           exact_odd;
  logic           sync_hit;
  logic           sync_align;
  logic           sync_soft;
  logic           timeout_hit;
  logic           byte_done;

  assign hist_shift = {Serial_B2, Serial_B1, hist[9:3]};

  // Even window ends on the B2 bit of the latest pair, odd window on B1.
  assign win_even = hist[9:2];
  assign win_odd  = hist[8:1];
  assign win_sel  = align ? win_odd : win_even;

  assign exact_even = (win_even == SYNC_WORD);
  assign exact_odd  = (win_odd  == SYNC_WORD);

`ifdef RX_SYNC_ERR_EN
  logic near_even;
  logic near_odd;

  // True when exactly one bit of x is set, i.e. Hamming distance 1.
  function automatic logic one_bit_set(input logic [7:0] x);
    return (x != 8'd0) && ((x & (x - 8'd1)) == 8'd0);
  endfunction

  assign near_even = one_bit_set(win_even ^ SYNC_WORD);
  assign near_odd  = one_bit_set(win_odd  ^ SYNC_WORD);
`endif

  // Sync detection priority: exact matches beat 1-bit matches, and within
  // a class the even offset beats the odd one.
  always_comb begin
    sync_hit   = 1'b0;
    sync_align = 1'b0;
    sync_soft  = 1'b0;
    if (exact_even) begin
      sync_hit = 1'b1;
    end else if (exact_odd) begin
      sync_hit   = 1'b1;
      sync_align = 1'b1;
`ifdef RX_SYNC_ERR_EN
    end else if (near_even) begin
      sync_hit  = 1'b1;
      sync_soft = 1'b1;
    end else if (near_odd) begin
      sync_hit   = 1'b1;
      sync_align = 1'b1;
      sync_soft  = 1'b1;
`endif
    end
  end

  assign timeout_hit = (HUNT_TIMEOUT != 0) && (hunt_cnt == HUNT_LAST);
  assign byte_done   = (state == ST_LOCKED) && (pair_cnt == 2'd3);
  assign RX_locked   = (state == ST_LOCKED);

  // Main state register and latched alignment. A match found while hunting
  // locks immediately; only Enable falling leaves LOCKED.
  always_ff @(posedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      state <= ST_IDLE;
      align <= 1'b0;
    end else if (!Enable) begin
      state <= ST_IDLE;
      align <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_HUNT;
        ST_HUNT: begin
          if (sync_hit) begin
            state <= ST_LOCKED;
            align <= sync_align;
          end
        end
        ST_LOCKED: state <= ST_LOCKED;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // History shift register. It is cleared while idle so that hunting always
  // starts from a clean slate.
  always_ff @(posedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      hist <= '0;
    end else if (!Enable || (state == ST_IDLE)) begin
      hist <= '0;
    end else begin
      hist <= hist_shift;
    end
  end

  // Pair counter (byte phase while locked) and hunt timeout counter. A sync
  // match takes precedence over a timeout falling in the same cycle.
  always_ff @(posedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      pair_cnt <= 2'd0;
      hunt_cnt <= '0;
    end else if (!Enable) begin
      pair_cnt <= 2'd0;
      hunt_cnt <= '0;
    end else begin
      case (state)
        ST_HUNT: begin
          pair_cnt <= 2'd0;
          if (sync_hit || timeout_hit) begin
            hunt_cnt <= '0;
          end else begin
            hunt_cnt <= hunt_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          pair_cnt <= pair_cnt + 2'd1;
          hunt_cnt <= '0;
        end
        default: begin
          pair_cnt <= 2'd0;
          hunt_cnt <= '0;
        end
      endcase
    end
  end

  // Status pulses. All are one cycle wide and are suppressed as soon as
  // Enable drops.
  always_ff @(posedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      SyncHS         <= 1'b0;
      ErrSotHS       <= 1'b0;
      ErrSyncTimeout <= 1'b0;
    end else begin
      SyncHS         <= Enable && (state == ST_HUNT) && sync_hit;
      ErrSotHS       <= Enable && (state == ST_HUNT) && sync_hit && sync_soft;
      ErrSyncTimeout <= Enable && (state == ST_HUNT) && !sync_hit && timeout_hit;
    end
  end

  // Byte output. The window is captured on the 3->0 wrap of the pair
  // counter and the strobe follows one cycle later, so the data register is
  // already stable when the strobe is seen. The data register holds its last
  // value across disable; only reset clears it.
  always_ff @(posedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      RX_BYTE_DATA  <= 8'd0;
      byte_pend     <= 1'b0;
      RX_BYTE_valid <= 1'b0;
    end else if (!Enable) begin
      byte_pend     <= 1'b0;
      RX_BYTE_valid <= 1'b0;
    end else begin
      byte_pend     <= byte_done;
      RX_BYTE_valid <= byte_pend;
      if (byte_done) begin
        RX_BYTE_DATA <= win_sel;
      end
    end
  end

endmodule
